load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-side consumer of the decoder's `mem_w` control word, which is `{funct3, store_en}`. The unit accepts one load or store per handshake from the execute stage and checks alignment. It drives a word-addressed data bus with byte strobes and a req/gnt/rvalid handshake, then returns sign- or zero-extended load data, or store completion, to writeback. It sits between the execute stage and data memory, and stalls the pipeline while an access is outstanding.

## Interface
- `ADDR_W`, 32, byte-address width.
- `RD_W`, 5, destination register index width.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  execute stage presents an access.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `mem_w`  in  4  `{funct3[2:0], store_en}`.
- `is_load`  in  1  access is a load.
- `addr`  in  ADDR_W  byte address.
- `wdata`  in  32  store source (rs2).
- `rd`  in  RD_W  load destination register.
- `bus_req`  out  1  bus request, held until granted.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- `bus_wstrb`  out  4  byte-lane write strobes.
- `bus_wdata`  out  32  lane-replicated write data.
- `bus_gnt`  in  1  bus accepts the request this cycle.
- `bus_rvalid`  in  1  read data valid.
- `bus_rdata`  in  32  read data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_err`  out  1  misaligned or illegal access; qualified by `rsp_valid`.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_rd`  out  RD_W  latched `rd`.
- `stall`  out  1  high in REQ, WAIT and RESP.

## Operation
- **FSM states:** IDLE, REQ, WAIT, RESP.
- **Accept:** `req_valid & req_ready` in IDLE latches `mem_w`, `is_load`, `addr`, `wdata` and `rd`.
- **Illegal access:** any of the following goes to RESP with `rsp_err`=1 and no bus activity.
  - `store_en` and `is_load` both high, or both low.
  - Store `funct3` outside {000, 001, 010}.
  - Load `funct3` outside {000, 001, 010, 100, 101}.
- **Misaligned access:** goes to RESP with `rsp_err`=1 and no bus activity.
  - Halfword with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
- **Legal access:** goes to REQ.
- **REQ:** `bus_req`=1.
  - On `bus_gnt`, a store goes to RESP and a load goes to WAIT.
- **WAIT:** `bus_rvalid` captures `bus_rdata`, then goes to RESP. `bus_rvalid` in any other state is ignored.
- **RESP:** `rsp_valid`=1 for exactly one cycle, then IDLE.
- **Store lanes:**
  - SB: strobe = `4'b0001 << addr[1:0]`, data = byte replicated ×4.
  - SH: strobe = `0011` or `1100` per `addr[1]`, data = halfword replicated ×2.
  - SW: strobe = `1111`.
- **Load extension:** select the lane by `addr[1:0]`.
  - LB and LH sign-extend from bit 7 or bit 15 of the selected lane, never from `bus_rdata[31]`.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- **Reset:** all outputs are 0 and the FSM is in IDLE. Reset asserted mid-access drops `bus_req` immediately and abandons the access. A late `bus_rvalid` after reset is ignored.

## Timing
- **Outputs:** all bus and response outputs are registered or decoded from state; no combinational path from `bus_*` inputs to `bus_req`.
- **Accept:** at cycle T.
  - `bus_req` is high from T+1.
  - An error gives `rsp_valid` at T+1.
- **Store:** granted at cycle G gives `rsp_valid` at G+1.
- **Load:** granted at G waits for `bus_rvalid` at the earliest at G+1. `bus_rvalid` at R gives `rsp_valid` and `rsp_rdata` at R+1.
- **Throughput:**
  - `req_ready` is 0 from T+1 until the cycle after `rsp_valid`.
  - Minimum 3 cycles per store and 4 per load.
- **Bus outputs:** `bus_addr`, `bus_we`, `bus_wstrb` and `bus_wdata` are stable while `bus_req`=1.

## Structure
- **`lsu_pkg`** holds:
  - `funct3` enum: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
  - `lsu_state_e`.
  - Strobe constants.
- **Sub-module `load_align`:** combinational lane select and extension. Inputs: `funct3`, `addr[1:0]`, `rdata`. Output: the 32-bit result.

## Test plan
- **SB:** `mem_w`=0001, `addr`=0x1003, `wdata`=0xA5 → `bus_addr`=0x1000, `bus_wstrb`=1000, `bus_wdata`=0xA5A5A5A5; `rsp_valid` one cycle after `bus_gnt`.
- **LB:** `addr`=0x2001, `bus_rdata`=0x0000_8000 → `rsp_rdata`=0xFFFF_FF80. LBU on the same stimulus → 0x0000_0080.
- **Misaligned LW:** `addr`=0x2002 → `rsp_valid` and `rsp_err` at T+1, `bus_req` never asserted, `rsp_rdata`=0.
- **Delayed grant and rvalid:** LH at `addr`=0x3002 with `bus_gnt` delayed 3 cycles and `bus_rvalid` 2 cycles later, `bus_rdata`=0x7FFF_0000 → `bus_req` held and stable through the delay; `rsp_rdata`=0x0000_7FFF; `stall` high throughout.
- **Reset in WAIT:** `rst` pulsed while in WAIT → `bus_req`, `stall` and `rsp_valid` go to 0 immediately. A subsequent `bus_rvalid` produces no response, and the next request is accepted normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  // Memory access width/sign encoding carried in funct3.
  typedef enum logic [2:0] {
    LsByte      = 3'b000,
    LsHalf      = 3'b001,
    LsWord      = 3'b010,
    LsByteU     = 3'b100,
    LsHalfU     = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } lsu_state_e;

  localparam logic [3:0] StrbNone   = 4'b0000;
  localparam logic [3:0] StrbByte0  = 4'b0001;
  localparam logic [3:0] StrbLoHalf = 4'b0011;
  localparam logic [3:0] StrbHiHalf = 4'b1100;
  localparam logic [3:0] StrbWord   = 4'b1111;

endpackage

// File: rtl/load_align.sv
// Lane select and sign/zero extension of a word read from the data bus.
module load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte lane.
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
  end

  assign half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Extend the selected lane; sign comes from the lane, not the bus MSB.
  always_comb begin
    result_o = '0;
    case (funct3_i)
      LsByte:  result_o = {{24{byte_sel[7]}}, byte_sel};
      LsHalf:  result_o = {{16{half_sel[15]}}, half_sel};
      LsWord:  result_o = rdata_i;
      LsByteU: result_o = {24'b0, byte_sel};
      LsHalfU: result_o = {16'b0, half_sel};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: checks legality/alignment, drives the data bus, returns load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        mem_w,
  input  logic              is_load,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [RD_W-1:0]   rd,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic [RD_W-1:0]   rsp_rd,
  output logic              stall
);

  lsu_state_e        state_q, state_d;
  logic [2:0]        funct3_q;
  logic              is_load_q;
  logic [ADDR_W-1:0] addr_q;
  logic [RD_W-1:0]   rd_q;
  logic              err_q;
  logic              we_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       load_result;

  logic              accept;
  logic              acc_ok;
  logic              kind_ok;
  logic              f3_ok;
  logic              aligned;
  logic              is_store;
  logic [3:0]        strb_new;
  logic [31:0]       wdata_new;

  assign accept   = (state_q == StIdle) && req_valid;
  assign is_store = mem_w[0];

  // Classify the incoming request and build its store lanes.
  always_comb begin
    kind_ok   = is_store ^ is_load;
    f3_ok     = 1'b0;
    aligned   = 1'b1;
    strb_new  = StrbNone;
    wdata_new = '0;
    case (mem_w[3:1])
      LsByte: begin
        f3_ok     = 1'b1;
        strb_new  = StrbByte0 << addr[1:0];
        wdata_new = {4{wdata[7:0]}};
      end
      LsHalf: begin
        f3_ok     = 1'b1;
        aligned   = ~addr[0];
        strb_new  = addr[1] ? StrbHiHalf : StrbLoHalf;
        wdata_new = {2{wdata[15:0]}};
      end
      LsWord: begin
        f3_ok     = 1'b1;
        aligned   = (addr[1:0] == 2'b00);
        strb_new  = StrbWord;
        wdata_new = wdata;
      end
      LsByteU: f3_ok = is_load;
      LsHalfU: begin
        f3_ok   = is_load;
        aligned = ~addr[0];
      end
      default: f3_ok = 1'b0;
    endcase
    acc_ok = kind_ok & f3_ok & aligned;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_valid) state_d = acc_ok ? StReq : StResp;
      StReq:  if (bus_gnt) state_d = is_load_q ? StWait : StResp;
      StWait: if (bus_rvalid) state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Request capture at accept and load data capture on rvalid in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct3_q  <= '0;
      is_load_q <= 1'b0;
      addr_q    <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else if (accept) begin
      funct3_q  <= mem_w[3:1];
      is_load_q <= is_load;
      addr_q    <= addr;
      rd_q      <= rd;
      err_q     <= ~acc_ok;
      we_q      <= acc_ok & is_store;
      wstrb_q   <= (acc_ok & is_store) ? strb_new : StrbNone;
      wdata_q   <= (acc_ok & is_store) ? wdata_new : '0;
      rdata_q   <= '0;
    end else if (state_q == StWait && bus_rvalid) begin
      rdata_q   <= load_result;
    end
  end

  load_align u_load_align (
    .funct3_i (funct3_q),
    .addr_i   (addr_q[1:0]),
    .rdata_i  (bus_rdata),
    .result_o (load_result)
  );

  assign req_ready = (state_q == StIdle) & ~rst;
  assign stall     = (state_q != StIdle);
  assign bus_req   = (state_q == StReq);
  assign bus_we    = we_q;
  assign bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_wstrb = wstrb_q;
  assign bus_wdata = wdata_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_err   = err_q & rsp_valid;
  assign rsp_rdata = rdata_q;
  assign rsp_rd    = rd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  mem_w;
  logic        is_load;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        stall;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .RD_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mem_w      (mem_w),
    .is_load    (is_load),
    .addr       (addr),
    .wdata      (wdata),
    .rd         (rd),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wstrb  (bus_wstrb),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .rsp_rd     (rsp_rd),
    .stall      (stall)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full access with configurable grant/rvalid delays; all expectations passed in.
  task automatic access(input string tag, input logic [3:0] mw, input logic il,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                        input int gnt_dly, input int rv_dly, input logic [31:0] rdat,
                        input logic exp_err, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_data);
    for (int i = 0; i < 10 && !req_ready; i++) begin
      bus_gnt = 1'b1;
      bus_rvalid = 1'b1;
      tick();
    end
    bus_gnt = 1'b0;
    bus_rvalid = 1'b0;
    check_eq({tag, " ready"}, req_ready, 1);
    req_valid = 1'b1;
    mem_w = mw;
    is_load = il;
    addr = a;
    wdata = wd;
    rd = r;
    tick();
    req_valid = 1'b0;
    mem_w = 4'h0;
    addr = 32'hFFFF_FFFF;
    wdata = 32'h0BAD_F00D;
    check_eq({tag, " not_ready"}, req_ready, 0);
    if (exp_err) begin
      check_eq({tag, " err_valid"}, rsp_valid, 1);
      check_eq({tag, " err_flag"}, rsp_err, 1);
      check_eq({tag, " err_rdata"}, rsp_rdata, 0);
      check_eq({tag, " err_noreq"}, bus_req, 0);
    end else begin
      for (int i = 0; i <= gnt_dly; i++) begin
        check_eq({tag, " req"}, bus_req, 1);
        check_eq({tag, " addr"}, bus_addr, a & 32'hFFFF_FFFC);
        check_eq({tag, " we"}, bus_we, !il);
        if (!il) begin
          check_eq({tag, " strb"}, bus_wstrb, exp_strb);
          check_eq({tag, " wdata"}, bus_wdata, exp_wdata);
        end
        check_eq({tag, " stall"}, stall, 1);
        check_eq({tag, " early_rsp"}, rsp_valid, 0);
        bus_gnt = (i == gnt_dly);
        // rvalid outside WAIT must be ignored
        bus_rvalid = il && (i < gnt_dly);
        bus_rdata = 32'hDEAD_0000 | i;
        tick();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b0;
      end
      if (il) begin
        for (int j = 0; j < rv_dly; j++) begin
          check_eq({tag, " wait_noreq"}, bus_req, 0);
          check_eq({tag, " wait_stall"}, stall, 1);
          check_eq({tag, " wait_rsp"}, rsp_valid, 0);
          tick();
        end
        bus_rvalid = 1'b1;
        bus_rdata = rdat;
        tick();
        bus_rvalid = 1'b0;
        bus_rdata = 32'h5A5A_5A5A;
      end
      check_eq({tag, " rsp_valid"}, rsp_valid, 1);
      check_eq({tag, " rsp_err"}, rsp_err, 0);
      check_eq({tag, " rsp_rdata"}, rsp_rdata, exp_data);
      check_eq({tag, " rsp_rd"}, rsp_rd, r);
      check_eq({tag, " rsp_noreq"}, bus_req, 0);
      check_eq({tag, " rsp_stall"}, stall, 1);
    end
    tick();
    check_eq({tag, " pulse_end"}, rsp_valid, 0);
    check_eq({tag, " idle_noreq"}, bus_req, 0);
    check_eq({tag, " idle_stall"}, stall, 0);
    check_eq({tag, " idle_ready"}, req_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    mem_w = 4'h0;
    is_load = 1'b0;
    addr = '0;
    wdata = '0;
    rd = '0;
    bus_gnt = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata = '0;
    tick();
    tick();
    check_eq("rst req_ready", req_ready, 0);
    check_eq("rst bus_req", bus_req, 0);
    check_eq("rst stall", stall, 0);
    check_eq("rst rsp_valid", rsp_valid, 0);
    check_eq("rst bus_wstrb", bus_wstrb, 0);
    check_eq("rst bus_addr", bus_addr, 0);
    rst = 1'b0;
    tick();
    check_eq("post_rst ready", req_ready, 1);

    // Stores
    access("sb", 4'b0001, 1'b0, 32'h1003, 32'h0000_00A5, 5'd1, 0, 0, '0,
           1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    access("sh", 4'b0011, 1'b0, 32'h0006, 32'h1234_BEEF, 5'd2, 1, 0, '0,
           1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    access("sh_lo", 4'b0011, 1'b0, 32'h0008, 32'h0000_CAFE, 5'd2, 0, 0, '0,
           1'b0, 4'b0011, 32'hCAFE_CAFE, 32'h0);
    access("sw", 4'b0101, 1'b0, 32'h0010, 32'hDEAD_BEEF, 5'd3, 2, 0, '0,
           1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0);

    // Loads
    access("lb", 4'b0000, 1'b1, 32'h2001, '0, 5'd7, 0, 0, 32'h0000_8000,
           1'b0, 4'b0, 32'h0, 32'hFFFF_FF80);
    access("lbu", 4'b1000, 1'b1, 32'h2001, '0, 5'd8, 0, 0, 32'h0000_8000,
           1'b0, 4'b0, 32'h0, 32'h0000_0080);
    access("lb_msb", 4'b0000, 1'b1, 32'h2000, '0, 5'd9, 0, 0, 32'h8000_0000,
           1'b0, 4'b0, 32'h0, 32'h0000_0000);
    access("lb_b3", 4'b0000, 1'b1, 32'h2003, '0, 5'd9, 0, 1, 32'h7F00_00FF,
           1'b0, 4'b0, 32'h0, 32'h0000_007F);
    access("lh_dly", 4'b0010, 1'b1, 32'h3002, '0, 5'd10, 3, 2, 32'h7FFF_0000,
           1'b0, 4'b0, 32'h0, 32'h0000_7FFF);
    access("lh_neg", 4'b0010, 1'b1, 32'h0002, '0, 5'd11, 0, 0, 32'h8001_0000,
           1'b0, 4'b0, 32'h0, 32'hFFFF_8001);
    access("lhu", 4'b1010, 1'b1, 32'h0002, '0, 5'd12, 0, 0, 32'h8001_0000,
           1'b0, 4'b0, 32'h0, 32'h0000_8001);
    access("lw", 4'b0100, 1'b1, 32'h0044, '0, 5'd31, 1, 0, 32'h89AB_CDEF,
           1'b0, 4'b0, 32'h0, 32'h89AB_CDEF);

    // Errors: misaligned and illegal encodings
    access("lw_mis", 4'b0100, 1'b1, 32'h2002, '0, 5'd4, 0, 0, '0,
           1'b1, 4'b0, 32'h0, 32'h0);
    access("sh_mis", 4'b0011, 1'b0, 32'h2001, 32'h1234, 5'd4, 0, 0, '0,
           1'b1, 4'b0, 32'h0, 32'h0);
    access("lhu_mis", 4'b1010, 1'b1, 32'h2003, '0, 5'd4, 0, 0, '0,
           1'b1, 4'b0, 32'h0, 32'h0);
    access("both_hi", 4'b0001, 1'b1, 32'h0000, '0, 5'd4, 0, 0, '0,
           1'b1, 4'b0, 32'h0, 32'h0);
    access("both_lo", 4'b0100, 1'b0, 32'h0000, '0, 5'd4, 0, 0, '0,
           1'b1, 4'b0, 32'h0, 32'h0);
    access("st_f3", 4'b1001, 1'b0, 32'h0000, '0, 5'd4, 0, 0, '0,
           1'b1, 4'b0, 32'h0, 32'h0);
    access("ld_f3", 4'b0110, 1'b1, 32'h0000, '0, 5'd4, 0, 0, '0,
           1'b1, 4'b0, 32'h0, 32'h0);

    // Reset while waiting for read data
    req_valid = 1'b1;
    mem_w = 4'b0100;
    is_load = 1'b1;
    addr = 32'h0100;
    rd = 5'd5;
    tick();
    req_valid = 1'b0;
    check_eq("rw req", bus_req, 1);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    check_eq("rw wait_stall", stall, 1);
    check_eq("rw wait_noreq", bus_req, 0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rw rst_req", bus_req, 0);
    check_eq("rw rst_stall", stall, 0);
    check_eq("rw rst_rsp", rsp_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata = 32'h1111_2222;
    tick();
    bus_rvalid = 1'b0;
    check_eq("rw late_rsp", rsp_valid, 0);
    check_eq("rw late_stall", stall, 0);
    tick();
    check_eq("rw late_rsp2", rsp_valid, 0);
    check_eq("rw late_rdata", rsp_rdata, 0);
    access("after_rst", 4'b0100, 1'b1, 32'h0104, '0, 5'd6, 0, 0, 32'h0123_4567,
           1'b0, 4'b0, 32'h0, 32'h0123_4567);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
